// File: rtl/uart_regif_pkg.sv
// Shared definitions for the UART register-interface responder.
//   - register addresses on the 2-bit host bus
//   - bit positions inside the status register
//   - the state encoding used by both the TX and RX frame FSMs
//   - oversampling constants and the optional RX FIFO depth
package uart_regif_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DIVL = 2'b10;
  localparam logic [1:0] ADDR_DIVH = 2'b11;

  localparam int STAT_RX_FULL = 0;
  localparam int STAT_TX_BUSY = 1;
  localparam int STAT_OVR     = 2;
  localparam int STAT_FE      = 3;

  // Eight baud ticks per bit; the fourth tick of a bit is its middle.
  localparam int         OVERSAMPLE = 8;
  localparam logic [2:0] MID_TICK   = 3'd3;
  localparam logic [2:0] LAST_TICK  = 3'(OVERSAMPLE - 1);

  // Only used when UART_RXFIFO_EN is defined; must be a power of 2.
  localparam int RXFIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive side of the UART: 2-flop synchronizer on the asynchronous RxD,
// falling-edge start detect, mid-bit sampling (8N1, LSB first) and framing
// error detection.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   tick      : 1-cycle baud tick (8 per bit)
//   rxd       : raw serial input
//   rx_byte   : received byte, valid while rx_valid is high
//   rx_valid  : 1-cycle pulse, one per completed frame
//   rx_fe     : stop bit was 0 for the frame delivered with rx_valid
// Handshake: rx_valid is a push-only strobe with no ready; the consumer must
// take rx_byte/rx_fe on the cycle rx_valid is high or drop the byte.
module uart_rx_sampler
  import uart_regif_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_fe
);

  logic        sync1_q, sync2_q, prev_q;
  uart_state_e state_q, state_d;
  logic [2:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        fe_q, fe_d;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    valid_d    = 1'b0;
    fe_d       = fe_q;
    if (state_q == ST_IDLE) begin
      // Falling edge on the synchronized line starts a frame.
      if (!sync2_q && prev_q) begin
        state_d    = ST_START;
        tick_cnt_d = 3'd0;
      end
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + 3'd1;
      if (tick_cnt_q == MID_TICK) begin
        if (state_q == ST_START && sync2_q) begin
          state_d = ST_IDLE;              // glitch, not a real start bit
        end else if (state_q == ST_DATA) begin
          shift_d = {sync2_q, shift_q[7:1]};
        end else if (state_q == ST_STOP) begin
          // Deliver at mid-stop so a back-to-back start edge is not missed.
          valid_d = 1'b1;
          fe_d    = !sync2_q;
          state_d = ST_IDLE;
        end
      end
      if (tick_cnt_q == LAST_TICK) begin
        if (state_q == ST_START) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end else if (state_q == ST_DATA) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= 3'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
    end
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_fe    = fe_q;

endmodule

// File: rtl/uart_regif_responder.sv
// Register-mapped UART peripheral behind a simple host read/write/addr bus.
// Contains the baud generator, TX FSM and register decode; the receive path
// lives in uart_rx_sampler.
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   read, write    : 1-cycle bus strobes (may coincide; both execute)
//   addr, datain   : register select and write data
//   dataout        : registered read data, valid the cycle after read
//   RxD / TxD      : serial in (asynchronous) / serial out (idles high)
//   IACK / IRQ     : interrupt acknowledge pulse / level interrupt
// Build option: define UART_RXFIFO_EN to replace the single RX holding
// register with an RXFIFO_DEPTH-entry FIFO.
module uart_regif_responder
  import uart_regif_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'h0516
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read,
  input  logic       write,
  input  logic [1:0] addr,
  input  logic [7:0] datain,
  output logic [7:0] dataout,
  input  logic       RxD,
  output logic       TxD,
  input  logic       IACK,
  output logic       IRQ
);

  // ---------------- baud generator ----------------
  logic [15:0] div_q, div_d, baud_cnt_q, baud_cnt_d;
  logic        tick;
  logic        div_wr;

  assign tick   = (baud_cnt_q == div_q);
  assign div_wr = write && (addr == ADDR_DIVL || addr == ADDR_DIVH);
  assign baud_cnt_d = (div_wr || tick) ? 16'd0 : baud_cnt_q + 16'd1;

  // ---------------- TX FSM ----------------
  uart_state_e tx_state_q, tx_state_d;
  logic [2:0]  tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        txd_q, txd_d;
  logic        tx_done, tx_busy, wr_data;

  assign tx_busy = (tx_state_q != ST_IDLE);
  assign wr_data = write && (addr == ADDR_DATA);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_done    = 1'b0;
    if (tx_state_q == ST_IDLE) begin
      // Writes while busy fall through here and are dropped.
      if (wr_data) begin
        tx_state_d = ST_START;
        tx_tick_d  = 3'd0;
        tx_shift_d = datain;
        txd_d      = 1'b0;
      end
    end else if (tick) begin
      tx_tick_d = tx_tick_q + 3'd1;
      if (tx_tick_q == LAST_TICK) begin
        if (tx_state_q == ST_START) begin
          tx_state_d = ST_DATA;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end else if (tx_state_q == ST_DATA) begin
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_state_d = ST_IDLE;
          txd_d      = 1'b1;
          tx_done    = 1'b1;
        end
      end
    end
  end

  // ---------------- RX path ----------------
  logic [7:0] rx_byte;
  logic       rx_valid, rx_fe;

  uart_rx_sampler u_rx (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rxd      (RxD),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_fe    (rx_fe)
  );

  logic       pop;
  logic       rx_full, rx_overrun;
  logic [7:0] rx_head;

  assign pop = read && (addr == ADDR_DATA);

`ifdef UART_RXFIFO_EN
  localparam int PW = $clog2(RXFIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(RXFIFO_DEPTH);

  logic [7:0]    fifo_q [RXFIFO_DEPTH];
  logic [7:0]    fifo_d [RXFIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_pop, push;

  assign rx_full    = (count_q != '0);
  assign rx_head    = rx_full ? fifo_q[rd_ptr_q] : 8'h00;
  assign do_pop     = pop && rx_full;
  // A pop on the arrival cycle frees the slot the new byte needs.
  assign rx_overrun = rx_valid && (count_q == CNT_FULL) && !do_pop;
  assign push       = rx_valid && !rx_overrun;

  always_comb begin
    fifo_d   = fifo_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = rx_byte;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !do_pop)      count_d = count_q + 1'b1;
    else if (!push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q   <= '{default: 8'h00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       rx_full_q, rx_full_d;

  assign rx_full    = rx_full_q;
  assign rx_head    = rx_hold_q;
  // Same-cycle data read pops first, so the new byte loads without OVR.
  assign rx_overrun = rx_valid && rx_full_q && !pop;

  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_full_d = rx_full_q;
    if (pop) rx_full_d = 1'b0;
    if (rx_valid && !rx_overrun) begin
      rx_hold_d = rx_byte;
      rx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_hold_q <= 8'h00;
      rx_full_q <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
    end
  end
`endif

  // ---------------- register decode, status, IRQ ----------------
  logic [7:0] dataout_q, dataout_d, status;
  logic       fe_q, fe_d, ovr_q, ovr_d, irq_q, irq_d;

  always_comb begin
    status               = 8'h00;
    status[STAT_RX_FULL] = rx_full;
    status[STAT_TX_BUSY] = tx_busy;
    status[STAT_OVR]     = ovr_q;
    status[STAT_FE]      = fe_q;
  end

  always_comb begin
    dataout_d = dataout_q;
    div_d     = div_q;
    fe_d      = fe_q;
    ovr_d     = ovr_q;
    irq_d     = irq_q;
    if (read) begin
      case (addr)
        ADDR_DATA: dataout_d = rx_head;
        ADDR_STAT: dataout_d = status;
        ADDR_DIVL: dataout_d = div_q[7:0];
        ADDR_DIVH: dataout_d = div_q[15:8];
      endcase
    end
    if (write && addr == ADDR_DIVL) div_d[7:0]  = datain;
    if (write && addr == ADDR_DIVH) div_d[15:8] = datain;
    // Status read clears the sticky errors; a new error on the same cycle wins.
    if (read && addr == ADDR_STAT) begin
      fe_d  = 1'b0;
      ovr_d = 1'b0;
    end
    if (rx_valid && rx_fe) fe_d  = 1'b1;
    if (rx_overrun)        ovr_d = 1'b1;
    if (IACK) irq_d = 1'b0;
    if (tx_done || (rx_valid && !rx_overrun)) irq_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= DIV_RESET;
      baud_cnt_q <= 16'd0;
      tx_state_q <= ST_IDLE;
      tx_tick_q  <= 3'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
      dataout_q  <= 8'h00;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      dataout_q  <= dataout_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
      irq_q      <= irq_d;
    end
  end

  assign dataout = dataout_q;
  assign TxD     = txd_q;
  assign IRQ     = irq_q;

endmodule
